// File: rtl/conv_pkg.sv
// Shared constants and sizing helpers for the 3x3 convolution window generator.
package conv_pkg;

   localparam int unsigned KSIZE = 3;
   localparam int unsigned KAREA = KSIZE * KSIZE;

   // Flattened window width for a given pixel width.
   function automatic int unsigned win_width(input int unsigned data_w);
      return KAREA * data_w;
   endfunction

   // Counter width able to hold 0..n-1 (at least one bit).
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   localparam int unsigned IMG_W_DEF  = 28;
   localparam int unsigned IMG_H_DEF  = 28;
   localparam int unsigned DATA_W_DEF = 8;
   localparam int unsigned COL_W_DEF  = cnt_width(IMG_W_DEF);
   localparam int unsigned ROW_W_DEF  = cnt_width(IMG_H_DEF);

endpackage

// File: rtl/line_buffer.sv
// One image line of storage: synchronous write, combinational read of the
// pre-write contents at the same address (the tap).
module line_buffer #(
   parameter int unsigned DEPTH  = 28,
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 5
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] tap
);

   logic [DATA_W-1:0] mem [DEPTH];

   // Contents are never cleared; every location is rewritten before it is observed.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

   assign tap = mem[addr];

endmodule

// File: rtl/conv_window_gen.sv
// Raster-order pixel stream to 3x3 sliding window generator (no padding).
// Optional build macro OUT_REG_EN adds one register stage on all outputs.
module conv_window_gen
   import conv_pkg::*;
#(
   parameter int unsigned IMG_W  = 28,
   parameter int unsigned IMG_H  = 28,
   parameter int unsigned DATA_W = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       sof_i,
   input  logic                       pix_valid_i,
   input  logic [DATA_W-1:0]          pix_i,
   output logic                       win_valid_o,
   output logic [KAREA*DATA_W-1:0]    win_o,
   output logic                       frame_done_o
);

   localparam int unsigned COL_W = cnt_width(IMG_W);
   localparam int unsigned ROW_W = cnt_width(IMG_H);
   localparam int unsigned WIN_W = win_width(DATA_W);

   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

   logic [COL_W-1:0] col_q, col_d, col_cur;
   logic [ROW_W-1:0] row_q, row_d, row_cur;
   logic             col_last, row_last, win_hit, frame_end;

   logic [DATA_W-1:0] tap0, tap1;
   logic [DATA_W-1:0] new_col [KSIZE];
   logic [DATA_W-1:0] win_q [KSIZE][KSIZE];
   logic [DATA_W-1:0] win_d [KSIZE][KSIZE];
   logic [WIN_W-1:0]  win_flat;

   logic              valid_q, done_q;
   logic [WIN_W-1:0]  wout_q;

   // sof_i forces the current pixel to be treated as position (0,0).
   assign col_cur   = sof_i ? '0 : col_q;
   assign row_cur   = sof_i ? '0 : row_q;
   assign col_last  = (col_cur == COL_LAST);
   assign row_last  = (row_cur == ROW_LAST);
   assign win_hit   = pix_valid_i && (row_cur >= ROW_W'(2)) && (col_cur >= COL_W'(2));
   assign frame_end = pix_valid_i && col_last && row_last;

   // Next raster position: advance on accepted pixel, sof_i alone just rewinds.
   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (pix_valid_i) begin
         if (col_last) begin
            col_d = '0;
            row_d = row_last ? '0 : row_cur + ROW_W'(1);
         end else begin
            col_d = col_cur + COL_W'(1);
            row_d = row_cur;
         end
      end else if (sof_i) begin
         col_d = '0;
         row_d = '0;
      end
   end

   // Position counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         col_q <= '0;
         row_q <= '0;
      end else begin
         col_q <= col_d;
         row_q <= row_d;
      end
   end

   // lb0 holds row-1, lb1 holds row-2; lb1 is fed with lb0's old value.
   line_buffer #(
      .DEPTH  (IMG_W),
      .DATA_W (DATA_W),
      .ADDR_W (COL_W)
   ) u_lb0 (
      .clk   (clk),
      .we    (pix_valid_i),
      .addr  (col_cur),
      .wdata (pix_i),
      .tap   (tap0)
   );

   line_buffer #(
      .DEPTH  (IMG_W),
      .DATA_W (DATA_W),
      .ADDR_W (COL_W)
   ) u_lb1 (
      .clk   (clk),
      .we    (pix_valid_i),
      .addr  (col_cur),
      .wdata (tap0),
      .tap   (tap1)
   );

   assign new_col[0] = tap1;
   assign new_col[1] = tap0;
   assign new_col[2] = pix_i;

   // Shift every window row left and append the new column; flatten row-major.
   always_comb begin
      win_flat = '0;
      for (int i = 0; i < KSIZE; i++) begin
         for (int j = 0; j < KSIZE - 1; j++) begin
            win_d[i][j] = win_q[i][j+1];
         end
         win_d[i][KSIZE-1] = new_col[i];
      end
      for (int i = 0; i < KSIZE; i++) begin
         for (int j = 0; j < KSIZE; j++) begin
            win_flat[WIN_W-1-DATA_W*(KSIZE*i+j) -: DATA_W] = win_d[i][j];
         end
      end
   end

   // Window shift registers; stale columns after a row wrap are masked by win_hit.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < KSIZE; i++) begin
            for (int j = 0; j < KSIZE; j++) begin
               win_q[i][j] <= '0;
            end
         end
      end else if (pix_valid_i) begin
         win_q <= win_d;
      end
   end

   // First output stage: win_o only updates on a valid window, holding otherwise.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         wout_q  <= '0;
      end else begin
         valid_q <= win_hit;
         done_q  <= frame_end;
         if (win_hit) begin
            wout_q <= win_flat;
         end
      end
   end

`ifdef OUT_REG_EN
   logic             valid_r, done_r;
   logic [WIN_W-1:0] wout_r;

   // Extra retiming stage; all three outputs delayed together.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_r <= 1'b0;
         done_r  <= 1'b0;
         wout_r  <= '0;
      end else begin
         valid_r <= valid_q;
         done_r  <= done_q;
         wout_r  <= wout_q;
      end
   end

   assign win_valid_o  = valid_r;
   assign frame_done_o = done_r;
   assign win_o        = wout_r;
`else
   assign win_valid_o  = valid_q;
   assign frame_done_o = done_q;
   assign win_o        = wout_q;
`endif

endmodule

// File: tb/tb_conv_window_gen.sv
// Self-checking bench for conv_window_gen on a 5x5 image with a behavioural
// frame model (image array + expected-window queue stamped with output cycle).
module tb_conv_window_gen;

   localparam int W = 5;
   localparam int H = 5;
`ifdef OUT_REG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   typedef struct {
      int          cyc;
      logic [71:0] win;
      logic        fd;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sof = 1'b0;
   logic        pix_valid = 1'b0;
   logic [7:0]  pix = 8'h00;
   logic        win_valid;
   logic [71:0] win;
   logic        frame_done;

   int          cyc = 0;
   logic        rst_seen = 1'b1;
   int          n_cmp = 0;
   int          n_bad = 0;

   // model state
   logic [7:0]  img [H][W];
   int          mr = 0;
   int          mc = 0;
   exp_t        q[$];
   logic [71:0] last_win = '0;

   // per-section observations
   int          sec_strobes = 0;
   int          sec_fd = 0;
   logic [71:0] sec_wins[$];

   conv_window_gen #(
      .IMG_W  (W),
      .IMG_H  (H),
      .DATA_W (8)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .sof_i        (sof),
      .pix_valid_i  (pix_valid),
      .pix_i        (pix),
      .win_valid_o  (win_valid),
      .win_o        (win),
      .frame_done_o (frame_done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc      <= cyc + 1;
      rst_seen <= rst;
   end

   task automatic chk(input string name, input logic [71:0] act, input logic [71:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, act, expv);
      end
   endtask

   // Per-cycle comparison against the model queue.
   always @(negedge clk) begin
      if (win_valid === 1'b1) begin
         sec_strobes++;
         sec_wins.push_back(win);
         if (frame_done === 1'b1) sec_fd++;
      end
      if (rst_seen) begin
         chk("reset_valid", {71'd0, win_valid}, 72'd0);
         chk("reset_done", {71'd0, frame_done}, 72'd0);
         chk("reset_win", win, 72'd0);
         last_win = '0;
         while (q.size() > 0 && q[0].cyc <= cyc) void'(q.pop_front());
      end else if (q.size() > 0 && q[0].cyc == cyc) begin
         exp_t e;
         e = q.pop_front();
         chk("win_valid", {71'd0, win_valid}, 72'd1);
         chk("win", win, e.win);
         chk("frame_done", {71'd0, frame_done}, {71'd0, e.fd});
         last_win = e.win;
      end else begin
         chk("idle_valid", {71'd0, win_valid}, 72'd0);
         chk("idle_done", {71'd0, frame_done}, 72'd0);
         chk("hold_win", win, last_win);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drive one pixel and record what the model says it must produce.
   task automatic drive_pix(input logic [7:0] v, input bit s);
      logic [71:0] w;
      exp_t        e;
      pix_valid = 1'b1;
      pix = v;
      sof = s;
      if (s) begin
         mr = 0;
         mc = 0;
      end
      img[mr][mc] = v;
      if (mr >= 2 && mc >= 2) begin
         w = '0;
         for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
               w = {w[63:0], img[mr-2+i][mc-2+j]};
         e.cyc = cyc + LAT;
         e.win = w;
         e.fd  = (mr == H - 1 && mc == W - 1);
         q.push_back(e);
      end
      if (mc == W - 1) begin
         mc = 0;
         mr = (mr == H - 1) ? 0 : mr + 1;
      end else begin
         mc = mc + 1;
      end
      step();
      pix_valid = 1'b0;
      sof = 1'b0;
   endtask

   task automatic send_frame(input int base, input int max_gap, input bit rnd_val);
      logic [7:0] v;
      for (int k = 0; k < W * H; k++) begin
         v = rnd_val ? 8'($urandom_range(0, 255)) : 8'(base + k);
         drive_pix(v, k == 0);
         repeat ($urandom_range(0, max_gap)) step();
      end
   endtask

   task automatic new_section();
      sec_strobes = 0;
      sec_fd = 0;
      sec_wins.delete();
   endtask

   task automatic drain();
      repeat (LAT + 3) step();
   endtask

   task automatic check_std(input string tag, input int n_exp);
      chk({tag, "_count"}, 72'(sec_strobes), 72'(n_exp));
      chk({tag, "_fd"}, 72'(sec_fd), 72'(n_exp / 9));
      if (sec_wins.size() >= 9) begin
         chk({tag, "_first"}, sec_wins[0], 72'h00_01_02_05_06_07_0A_0B_0C);
         chk({tag, "_last"}, sec_wins[8], 72'h0C_0D_0E_11_12_13_16_17_18);
      end else begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s_windows: got %0d windows, expected at least 9", tag, sec_wins.size());
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time bound");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) step();
      chk("por_win", win, 72'd0);
      chk("por_valid", {71'd0, win_valid}, 72'd0);
      rst = 1'b0;
      mr = 0;
      mc = 0;
      step();

      // contiguous frame 0..24
      new_section();
      send_frame(0, 0, 1'b0);
      drain();
      check_std("contig", 9);

      // same stream with random gaps
      new_section();
      send_frame(0, 3, 1'b0);
      drain();
      check_std("gaps", 9);

      // back-to-back frames 0..24 then 100..124
      new_section();
      send_frame(0, 0, 1'b0);
      send_frame(100, 0, 1'b0);
      drain();
      check_std("b2b", 18);
      if (sec_wins.size() >= 10)
         chk("b2b_second_first", sec_wins[9], 72'h64_65_66_69_6A_6B_6E_6F_70);

      // reset mid-frame after pixel 14, then a fresh frame
      for (int k = 0; k < 15; k++) drive_pix(8'(k), k == 0);
      rst = 1'b1;
      step();
      step();
      chk("midreset_win", win, 72'd0);
      rst = 1'b0;
      mr = 0;
      mc = 0;
      step();
      new_section();
      send_frame(0, 0, 1'b0);
      drain();
      check_std("midreset", 9);

      // sof restart at pixel 7
      new_section();
      for (int k = 0; k < 7; k++) drive_pix(8'(k), k == 0);
      send_frame(0, 0, 1'b0);
      drain();
      check_std("sofrestart", 9);

      // random values, random gaps, two frames
      new_section();
      send_frame(0, 3, 1'b1);
      send_frame(0, 2, 1'b1);
      drain();
      chk("random_count", 72'(sec_strobes), 72'd18);
      chk("random_fd", 72'(sec_fd), 72'd2);

      chk("queue_empty", 72'(q.size()), 72'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
